decode_dispatch_ctrl: RTL and testbench

Instruction queue and sequencing controller that sits between fetch and the combinational decoder, then hands decoded instructions to the per-FU reservation stations. It buffers fetched instructions in a circular queue and presents the head entry to the decoder. Each entry is dispatched only when the reservation station for its target FU has room. It also enforces halt (WFI), illegal-instruction trap and flush sequencing for the front end.

---
 rtl/decode_dispatch_ctrl.sv | 113 +++++++++++
 tb/tb_decode_dispatch_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/decode_dispatch_ctrl.sv
// Front-end instruction queue feeding the decoder and dispatching decoded
// entries to per-FU reservation stations, with halt, trap and flush sequencing.
module decode_dispatch_ctrl #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned XLEN  = 32
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     in_valid,
    input  logic [31:0]              in_inst,
    input  logic [XLEN-1:0]          in_pc,
    output logic                     in_ready,
    input  logic                     flush,
    output logic                     dec_valid,
    output logic [31:0]              dec_inst,
    output logic [XLEN-1:0]          dec_pc,
    input  logic [1:0]               dec_fu,
    input  logic                     dec_illegal,
    input  logic                     dec_halt,
    input  logic [3:0]               fu_ready,
    output logic [3:0]               disp_fu_sel,
    output logic                     disp_valid,
    output logic                     halted,
    output logic                     illegal_trap,
    output logic [$clog2(DEPTH):0]   queue_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {
        S_RUN,
        S_HALTED,
        S_TRAP
    } state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   head_ptr, tail_ptr;
    logic [CW-1:0]   count;
    logic [31:0]     inst_mem [DEPTH];
    logic [XLEN-1:0] pc_mem   [DEPTH];

    logic running;
    logic enq;
    logic fire;

    assign running      = (state == S_RUN);
    assign in_ready     = (count != CW'(DEPTH)) & running;
    assign dec_valid    = (count != '0) & running;
    assign disp_valid   = dec_valid & ~dec_illegal;
    assign fire         = disp_valid & fu_ready[dec_fu];
    assign disp_fu_sel  = fire ? (4'b0001 << dec_fu) : 4'b0000;
    assign halted       = (state == S_HALTED);
    assign illegal_trap = (state == S_TRAP);
    assign queue_count  = count;

    // Head data is masked while nothing is presented so idle outputs read zero.
    assign dec_inst = dec_valid ? inst_mem[head_ptr] : '0;
    assign dec_pc   = dec_valid ? pc_mem[head_ptr]   : '0;

    // A flush drops any enqueue offered in the same cycle.
    assign enq = in_valid & in_ready & ~flush;

    always_comb begin
        state_nxt = state;
        case (state)
            S_RUN: begin
                if (fire && dec_halt)
                    state_nxt = S_HALTED;
                else if (dec_valid && dec_illegal)
                    state_nxt = S_TRAP;
            end
            S_HALTED: state_nxt = S_HALTED;
            S_TRAP:   state_nxt = S_TRAP;
            default:  state_nxt = S_RUN;
        endcase
        if (flush)
            state_nxt = S_RUN;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= S_RUN;
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else if (flush) begin
            state    <= S_RUN;
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            state <= state_nxt;
            if (enq)
                tail_ptr <= tail_ptr + PW'(1);
            if (fire)
                head_ptr <= head_ptr + PW'(1);
            case ({enq, fire})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (enq) begin
            inst_mem[tail_ptr] <= in_inst;
            pc_mem[tail_ptr]   <= in_pc;
        end
    end

endmodule

// File: tb/tb_decode_dispatch_ctrl.sv
// Directed bench for decode_dispatch_ctrl; a tiny stand-in decoder derives
// fu/illegal/halt from instruction bits [1:0], [2] and [3].
module tb_decode_dispatch_ctrl;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        in_ready;
    logic        flush;
    logic        dec_valid;
    logic [31:0] dec_inst;
    logic [31:0] dec_pc;
    logic [1:0]  dec_fu;
    logic        dec_illegal;
    logic        dec_halt;
    logic [3:0]  fu_ready;
    logic [3:0]  disp_fu_sel;
    logic        disp_valid;
    logic        halted;
    logic        illegal_trap;
    logic [3:0]  queue_count;

    int total = 0;
    int bad   = 0;

    decode_dispatch_ctrl #(.DEPTH(8), .XLEN(32)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_inst(in_inst), .in_pc(in_pc), .in_ready(in_ready),
        .flush(flush),
        .dec_valid(dec_valid), .dec_inst(dec_inst), .dec_pc(dec_pc),
        .dec_fu(dec_fu), .dec_illegal(dec_illegal), .dec_halt(dec_halt),
        .fu_ready(fu_ready), .disp_fu_sel(disp_fu_sel), .disp_valid(disp_valid),
        .halted(halted), .illegal_trap(illegal_trap), .queue_count(queue_count)
    );

    always #5 clock = ~clock;

    assign dec_fu      = dec_inst[1:0];
    assign dec_illegal = dec_inst[2];
    assign dec_halt    = dec_inst[3];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge, then leave time for inputs to be set and outputs to settle.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] mk_inst(input int idx, input int fu);
        logic [31:0] v;
        v = 32'hA000_0000 | (32'(idx) << 8) | 32'(fu & 3);
        return v;
    endfunction

    initial begin
        int next_enq;
        int next_deq;
        int budget;

        reset_n = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0;
        flush = 1'b0; fu_ready = '0;
        tick(); tick();
        reset_n = 1'b1;
        #1;
        check("rst_count",  queue_count, 0);
        check("rst_ready",  in_ready, 1);
        check("rst_dvalid", dec_valid, 0);
        check("rst_sel",    disp_fu_sel, 0);
        check("rst_disp",   disp_valid, 0);
        check("rst_halt",   halted, 0);
        check("rst_trap",   illegal_trap, 0);
        check("rst_pc",     dec_pc, 0);

        // single pass
        in_valid = 1'b1; in_inst = 32'h0000_0033; in_pc = 32'h100; fu_ready = 4'b1000;
        #1;
        check("sp_nobypass", dec_valid, 0);
        tick();
        in_valid = 1'b0;
        #1;
        check("sp_dvalid", dec_valid, 1);
        check("sp_pc",     dec_pc, 32'h100);
        check("sp_inst",   dec_inst, 32'h0000_0033);
        check("sp_sel",    disp_fu_sel, 4'b1000);
        check("sp_count1", queue_count, 1);
        tick();
        check("sp_count0", queue_count, 0);
        check("sp_idle",   dec_valid, 0);

        // fill with fu_ready=0, then drain while enqueuing to 20 entries
        fu_ready = 4'b0000;
        next_enq = 0;
        next_deq = 0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_inst  = mk_inst(next_enq, next_enq);
            in_pc    = 32'h200 + 32'(4 * next_enq);
            #1;
            if (in_ready) next_enq++;
            tick();
        end
        in_valid = 1'b0;
        #1;
        check("full_count", queue_count, 8);
        check("full_ready", in_ready, 0);
        check("full_head",  dec_pc, 32'h200);
        check("full_sel",   disp_fu_sel, 0);

        fu_ready = 4'hF;
        in_valid = 1'b1;
        in_inst  = mk_inst(next_enq, next_enq);
        in_pc    = 32'h200 + 32'(4 * next_enq);
        #1;
        check("full_fire_noready", in_ready, 0);
        budget = 0;
        while (next_deq < 20 && budget < 100) begin
            in_valid = (next_enq < 20);
            in_inst  = mk_inst(next_enq, next_enq);
            in_pc    = 32'h200 + 32'(4 * next_enq);
            #1;
            if (disp_fu_sel != 4'b0000) begin
                check("wrap_pc",   dec_pc, 32'h200 + 32'(4 * next_deq));
                check("wrap_inst", dec_inst, mk_inst(next_deq, next_deq));
                check("wrap_sel",  disp_fu_sel, 4'b0001 << (next_deq % 4));
                next_deq++;
            end
            if (in_valid && in_ready) next_enq++;
            tick();
            budget++;
        end
        in_valid = 1'b0;
        #1;
        check("wrap_done",  next_deq, 20);
        check("wrap_count", queue_count, 0);

        // stall on fu 1
        fu_ready = 4'b1101;
        in_valid = 1'b1; in_inst = mk_inst(40, 1); in_pc = 32'h300;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_disp",  disp_valid, 1);
            check("stall_sel",   disp_fu_sel, 0);
            check("stall_pc",    dec_pc, 32'h300);
            check("stall_count", queue_count, 1);
            tick();
        end
        fu_ready = 4'b1111;
        #1;
        check("stall_go", disp_fu_sel, 4'b0010);
        tick();
        check("stall_empty", queue_count, 0);

        // halt: WFI then ADD
        fu_ready = 4'b0000;
        in_valid = 1'b1; in_inst = 32'h0000_0008; in_pc = 32'h400;
        tick();
        in_inst = 32'h0000_0010; in_pc = 32'h404;
        tick();
        in_valid = 1'b0;
        fu_ready = 4'hF;
        #1;
        check("halt_count2", queue_count, 2);
        check("halt_wfi_pc", dec_pc, 32'h400);
        check("halt_wfi_sel", disp_fu_sel, 4'b0001);
        tick();
        check("halt_flag",  halted, 1);
        check("halt_dv",    dec_valid, 0);
        check("halt_sel",   disp_fu_sel, 0);
        check("halt_ready", in_ready, 0);
        check("halt_count", queue_count, 1);
        tick();
        check("halt_sticky", halted, 1);
        check("halt_keep",   queue_count, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        check("hflush_count", queue_count, 0);
        check("hflush_halt",  halted, 0);
        check("hflush_ready", in_ready, 1);

        // illegal trap, then flush with concurrent enqueue
        in_valid = 1'b1; in_inst = 32'h0000_0004; in_pc = 32'h500;
        tick();
        in_valid = 1'b0;
        #1;
        check("ill_dv",   dec_valid, 1);
        check("ill_disp", disp_valid, 0);
        check("ill_sel",  disp_fu_sel, 0);
        tick();
        check("ill_trap",  illegal_trap, 1);
        check("ill_disp2", disp_valid, 0);
        check("ill_count", queue_count, 1);
        check("ill_ready", in_ready, 0);
        flush = 1'b1; in_valid = 1'b1; in_inst = 32'h0000_0001; in_pc = 32'h600;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        check("iflush_count", queue_count, 0);
        check("iflush_trap",  illegal_trap, 0);
        check("iflush_dv",    dec_valid, 0);
        tick();
        check("iflush_drop",  queue_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
